elevator_ctrl_n: RTL
====================

Name: elevator_ctrl_n

Overview:
- Parametrised N-floor elevator controller core that succeeds the two-floor controller.
- Latches car and hall calls, runs collective (directional) dispatch, times floor-to-floor travel and door dwell, and drives call lamps and status.
- Sits under the board top level. Upstream debounce/sync logic delivers one-cycle button pulses; the existing seven-segment/LED driver consumes cur_floor and status.

Parameters:
- FLOORS, 4, number of floors (2..16); floor 0 is the bottom.
- FLOOR_W, 2, width of the floor index; must be at least clog2(FLOORS).
- MOVE_CYCLES, 8, clock cycles to travel one floor (at least 2).
- DOOR_CYCLES, 6, clock cycles the door stays open (at least 2).
- CNT_W, 8, timer width; must hold max(MOVE_CYCLES, DOOR_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- hall_up_pb  in  FLOORS  one-cycle hall "up" pulses; bit FLOORS-1 is ignored.
- hall_dn_pb  in  FLOORS  one-cycle hall "down" pulses; bit 0 is ignored.
- car_pb  in  FLOORS  one-cycle car floor-button pulses.
- door_hold  in  1  level input; while high in DOOR_OPEN, the door timer reloads.
- cur_floor  out  FLOOR_W  current or last-passed floor.
- door_open  out  1  high in DOOR_OPEN.
- moving  out  1  high in MOVE_UP or MOVE_DN.
- dir_up  out  1  preferred/current direction; 1 = up.
- hall_up_lamp  out  FLOORS  latched hall-up calls.
- hall_dn_lamp  out  FLOORS  latched hall-down calls.
- car_lamp  out  FLOORS  latched car calls.

Behaviour:
- Reset (async, reset=0): state IDLE, cur_floor=0, all lamps 0, door_open=0, moving=0, dir_up=1, timers 0. Mid-move or mid-dwell reset aborts immediately; no call survives.
- Call latching: a pulse at cycle t sets the lamp bit at t+1. Lamps are sticky until served. Invalid bits (hall_up[FLOORS-1], hall_dn[0]) never set. Re-pressing a lit button has no effect.
- Definitions: above = any lamp bit at a floor > cur_floor; below = any lamp bit at a floor < cur_floor; here = car|up|dn lamp at cur_floor.
- States: IDLE, MOVE_UP, MOVE_DN, DOOR_OPEN. All outputs are registered.
- IDLE transitions:
  - If here: go to DOOR_OPEN and clear car[f].
    - If dir_up and above: clear up[f] only.
    - If !dir_up and below: clear dn[f] only.
    - Otherwise: clear both up[f] and dn[f].
  - Else if above and (dir_up or !below): MOVE_UP, dir_up=1.
  - Else if below: MOVE_DN, dir_up=0.
  - Else stay in IDLE.
- MOVE_UP / MOVE_DN:
  - On entry, load the move timer with MOVE_CYCLES-1. It decrements each cycle.
  - At 0: cur_floor ±1. Then evaluate stop at the new floor f, using lamps as of that cycle.
  - Stop in MOVE_UP if car[f] or up[f], or if nothing is above f.
  - Stop in MOVE_DN if car[f] or dn[f], or if nothing is below f.
  - On stop: go to DOOR_OPEN, clear car[f] and the same-direction hall bit. Clear the opposite hall bit only when nothing remains ahead; in that case dir_up flips.
  - Otherwise reload the timer and continue.
  - cur_floor never leaves 0..FLOORS-1.
- DOOR_OPEN:
  - Load the door timer with DOOR_CYCLES-1.
  - In the same cycle, a press of car_pb[f], or of the hall button that was just cleared at f, reloads the timer and is not latched.
  - door_hold=1 reloads the timer every cycle.
  - Other presses latch normally.
  - At timer 0 with no reload: go to IDLE (door_open=0 the next cycle).
- Simultaneous events:
  - A press and a clear of the same bit in one cycle: the clear wins, and the timer reloads.
  - Several presses in one cycle: all latch.
- Latency: a press at the current floor while in IDLE at cycle t gives lamp=1 at t+1, door_open=1 at t+2 with the lamp cleared, and door_open=0 at t+2+DOOR_CYCLES.

Test Plan (FLOORS=4, MOVE_CYCLES=8, DOOR_CYCLES=6):
- Reset, then release -> cur_floor=0, all lamps 0, door_open=0, moving=0, dir_up=1. Assert reset during MOVE_UP at floor 1 -> same values immediately, asynchronously.
- car_pb[0] pulse at t, in IDLE at floor 0 -> car_lamp[0]=1 at t+1; door_open=1 and car_lamp[0]=0 at t+2; door_open=0 at t+8.
- car_pb[3] pulse at floor 0 -> moving=1 from t+2; cur_floor steps 1, 2, 3 every 8 cycles; door_open when cur_floor=3; dir_up flips to 0; car_lamp[3] cleared.
- Collective dispatch while moving 0->3 for car_pb[3]:
  - hall_up_pb[2] pressed in the first segment -> stop at 2, hall_up_lamp[2] cleared.
  - hall_dn_pb[1] pressed -> no stop at 1 going up; served on the return trip.
- door_hold=1 for 20 cycles during DOOR_OPEN -> door_open held 20+6 cycles. Re-pressing car_pb[f] mid-dwell -> timer reloads, car_lamp[f] stays 0.
- Ignored bits: hall_up_pb[3] and hall_dn_pb[0] pulses -> lamps stay 0, state stays IDLE.

Source files
------------

// File: rtl/elevator_ctrl_n.sv
// N-floor collective elevator controller: latches car/hall calls, dispatches
// in the current direction, times floor travel and door dwell.
module elevator_ctrl_n #(
    parameter int FLOORS      = 4,
    parameter int FLOOR_W     = 2,
    parameter int MOVE_CYCLES = 8,
    parameter int DOOR_CYCLES = 6,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FLOORS-1:0]  hall_up_pb,
    input  logic [FLOORS-1:0]  hall_dn_pb,
    input  logic [FLOORS-1:0]  car_pb,
    input  logic               door_hold,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic               door_open,
    output logic               moving,
    output logic               dir_up,
    output logic [FLOORS-1:0]  hall_up_lamp,
    output logic [FLOORS-1:0]  hall_dn_lamp,
    output logic [FLOORS-1:0]  car_lamp
);

    typedef enum logic [1:0] {S_IDLE, S_MOVE_UP, S_MOVE_DN, S_DOOR_OPEN} state_t;

    localparam logic [FLOORS-1:0] ONE       = {{(FLOORS-1){1'b0}}, 1'b1};
    localparam logic [FLOORS-1:0] UP_VALID  = ~(ONE << (FLOORS - 1));
    localparam logic [FLOORS-1:0] DN_VALID  = ~ONE;
    localparam logic [CNT_W-1:0]  MOVE_LOAD = CNT_W'(MOVE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DOOR_LOAD = CNT_W'(DOOR_CYCLES - 1);

    state_t             state_q, state_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic               srv_up_q, srv_up_d, srv_dn_q, srv_dn_d;
    logic               open_q, moving_q;
    logic [FLOORS-1:0]  car_q, car_d, up_q, up_d, dn_q, dn_d;

    logic [FLOORS-1:0]  up_pb, dn_pb, calls, f_bit, n_bit;
    logic [FLOORS-1:0]  clr_car, clr_up, clr_dn, sup_car, sup_up, sup_dn;
    logic [FLOOR_W-1:0] n_floor;
    logic               going_up, ahead, same_hit, reload, entering;

    function automatic logic any_above(input logic [FLOORS-1:0] c, input logic [FLOOR_W-1:0] f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < FLOORS; i++) if (i > int'(f) && c[i]) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic any_below(input logic [FLOORS-1:0] c, input logic [FLOOR_W-1:0] f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < FLOORS; i++) if (i < int'(f) && c[i]) hit = 1'b1;
        return hit;
    endfunction

    assign up_pb    = hall_up_pb & UP_VALID;
    assign dn_pb    = hall_dn_pb & DN_VALID;
    assign calls    = car_q | up_q | dn_q;
    assign f_bit    = ONE << floor_q;
    assign going_up = (state_q == S_MOVE_UP);

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        state_d  = state_q;
        floor_d  = floor_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        srv_up_d = srv_up_q;
        srv_dn_d = srv_dn_q;
        n_floor  = floor_q;
        n_bit    = f_bit;
        ahead    = 1'b0;
        same_hit = 1'b0;
        reload   = 1'b0;
        sup_car  = '0;
        sup_up   = '0;
        sup_dn   = '0;

        case (state_q)
            S_IDLE: begin
                if ((calls & f_bit) != '0) begin
                    state_d = S_DOOR_OPEN;
                    cnt_d   = DOOR_LOAD;
                    if (dir_q && any_above(calls, floor_q)) begin
                        srv_up_d = 1'b1;
                        srv_dn_d = 1'b0;
                    end else if (!dir_q && any_below(calls, floor_q)) begin
                        srv_up_d = 1'b0;
                        srv_dn_d = 1'b1;
                    end else begin
                        srv_up_d = 1'b1;
                        srv_dn_d = 1'b1;
                    end
                end else if (any_above(calls, floor_q) && (dir_q || !any_below(calls, floor_q))) begin
                    state_d = S_MOVE_UP;
                    dir_d   = 1'b1;
                    cnt_d   = MOVE_LOAD;
                end else if (any_below(calls, floor_q)) begin
                    state_d = S_MOVE_DN;
                    dir_d   = 1'b0;
                    cnt_d   = MOVE_LOAD;
                end
            end
            S_MOVE_UP, S_MOVE_DN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    n_floor  = going_up ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
                    n_bit    = ONE << n_floor;
                    floor_d  = n_floor;
                    ahead    = going_up ? any_above(calls, n_floor) : any_below(calls, n_floor);
                    same_hit = going_up ? ((up_q & n_bit) != '0) : ((dn_q & n_bit) != '0);
                    if (((car_q & n_bit) != '0) || same_hit || !ahead) begin
                        state_d  = S_DOOR_OPEN;
                        cnt_d    = DOOR_LOAD;
                        srv_up_d = going_up || !ahead;
                        srv_dn_d = !going_up || !ahead;
                        // Turning around at the end of the run also answers the opposite hall call.
                        if (!ahead) dir_d = !going_up;
                    end else begin
                        cnt_d = MOVE_LOAD;
                    end
                end
            end
            S_DOOR_OPEN: begin
                sup_car = f_bit;
                sup_up  = srv_up_q ? f_bit : '0;
                sup_dn  = srv_dn_q ? f_bit : '0;
                reload  = door_hold || ((car_pb & sup_car) != '0) ||
                          ((up_pb & sup_up) != '0) || ((dn_pb & sup_dn) != '0);
                if (reload)             cnt_d   = DOOR_LOAD;
                else if (cnt_q == '0)   state_d = S_IDLE;
                else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        entering = (state_q != S_DOOR_OPEN) && (state_d == S_DOOR_OPEN);
        clr_car  = entering ? n_bit : '0;
        clr_up   = (entering && srv_up_d) ? n_bit : '0;
        clr_dn   = (entering && srv_dn_d) ? n_bit : '0;

        car_d = (car_q | car_pb) & ~clr_car & ~sup_car;
        up_d  = (up_q  | up_pb)  & ~clr_up  & ~sup_up;
        dn_d  = (dn_q  | dn_pb)  & ~clr_dn  & ~sup_dn;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            floor_q  <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b1;
            srv_up_q <= 1'b0;
            srv_dn_q <= 1'b0;
            open_q   <= 1'b0;
            moving_q <= 1'b0;
            car_q    <= '0;
            up_q     <= '0;
            dn_q     <= '0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            srv_up_q <= srv_up_d;
            srv_dn_q <= srv_dn_d;
            open_q   <= (state_d == S_DOOR_OPEN);
            moving_q <= (state_d == S_MOVE_UP) || (state_d == S_MOVE_DN);
            car_q    <= car_d;
            up_q     <= up_d;
            dn_q     <= dn_d;
        end
    end

    assign cur_floor    = floor_q;
    assign door_open    = open_q;
    assign moving       = moving_q;
    assign dir_up       = dir_q;
    assign hall_up_lamp = up_q;
    assign hall_dn_lamp = dn_q;
    assign car_lamp     = car_q;

endmodule
